eco32_core_mpu_crseq: RTL

- Control-register access sequencer for the MPU. It is the initiator side of the per-thread control-register file port: tid/addr, cra/crb write strobes and combinational read-back.
- Accepts move-to/move-from/bit-set/bit-clear requests from the execute stage and runs them as read-then-write sequences.
- Returns the old register values to the requester and enforces write protection on system-control addresses for unprivileged code.

---
 rtl/eco32_core_mpu_crseq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/eco32_core_mpu_crseq.sv
// Control-register access sequencer: runs MPU requests as read-then-write
// sequences on the per-thread control-register file and returns the old values.
module eco32_core_mpu_crseq #(
  parameter logic [31:0] PROT_MASK = 32'h0000_4500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  output logic        o_ack,
  input  logic        i_tid,
  input  logic [4:0]  i_addr,
  input  logic [2:0]  i_op,
  input  logic        i_priv,
  input  logic [31:0] i_data,
  output logic        o_tid,
  output logic [4:0]  o_addr,
  output logic        o_wra,
  output logic [31:0] o_cra,
  output logic        o_wrb,
  output logic        o_wri,
  output logic [31:0] o_crb,
  input  logic [31:0] i_cra,
  input  logic [31:0] i_crb,
  output logic        o_rsp_val,
  input  logic        i_rsp_rdy,
  output logic        o_rsp_tid,
  output logic [31:0] o_rsp_cra,
  output logic [31:0] o_rsp_crb,
  output logic        o_rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RSP} state_t;

  localparam logic [2:0] OP_READ  = 3'd0;
  localparam logic [2:0] OP_WR_A  = 3'd1;
  localparam logic [2:0] OP_WR_B  = 3'd2;
  localparam logic [2:0] OP_WR_I  = 3'd3;
  localparam logic [2:0] OP_SET_B = 3'd4;
  localparam logic [2:0] OP_CLR_B = 3'd5;

  state_t      state_q, state_d;
  logic        tid_q, priv_q, err_q;
  logic [4:0]  addr_q;
  logic [2:0]  op_q;
  logic [31:0] data_q, old_cra_q, old_crb_q;
  logic        wra_q, wrb_q, wri_q;
  logic        wra_d, wrb_d, wri_d;
  logic [31:0] cra_q, crb_q, cra_d, crb_d;
  logic        latch_req, capture_old, err_now;

  assign err_now = (op_q >= 3'd6) ||
                   ((op_q != OP_READ) && PROT_MASK[addr_q] && !priv_q);

  always_comb begin
    state_d     = state_q;
    latch_req   = 1'b0;
    capture_old = 1'b0;
    wra_d       = 1'b0;
    wrb_d       = 1'b0;
    wri_d       = 1'b0;
    cra_d       = cra_q;
    crb_d       = crb_q;
    case (state_q)
      S_IDLE: begin
        if (i_req) begin
          latch_req = 1'b1;
          state_d   = S_RD;
        end
      end
      S_RD: begin
        capture_old = 1'b1;
        if (op_q == OP_READ || err_now) begin
          state_d = S_RSP;
        end else begin
          state_d = S_WR;
          // Write data is built from the live read-back so the strobes can be registered
          case (op_q)
            OP_WR_A: begin
              wra_d = 1'b1;
              cra_d = data_q;
              crb_d = data_q;
            end
            OP_WR_B: begin
              wrb_d = 1'b1;
              wri_d = 1'b1;
              crb_d = data_q;
            end
            OP_WR_I: begin
              wri_d = 1'b1;
              crb_d = {i_crb[31:1], data_q[0]};
            end
            OP_SET_B, OP_CLR_B: begin
              crb_d = (op_q == OP_SET_B) ? (i_crb | data_q) : (i_crb & ~data_q);
              wrb_d = |data_q[31:1];
              wri_d = data_q[0];
            end
            default: ;
          endcase
        end
      end
      S_WR: state_d = S_RSP;
      S_RSP: begin
        if (i_rsp_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tid_q     <= 1'b0;
      addr_q    <= '0;
      op_q      <= '0;
      priv_q    <= 1'b0;
      data_q    <= '0;
      old_cra_q <= '0;
      old_crb_q <= '0;
      err_q     <= 1'b0;
      wra_q     <= 1'b0;
      wrb_q     <= 1'b0;
      wri_q     <= 1'b0;
      cra_q     <= '0;
      crb_q     <= '0;
    end else begin
      state_q <= state_d;
      wra_q   <= wra_d;
      wrb_q   <= wrb_d;
      wri_q   <= wri_d;
      cra_q   <= cra_d;
      crb_q   <= crb_d;
      if (latch_req) begin
        tid_q  <= i_tid;
        addr_q <= i_addr;
        op_q   <= i_op;
        priv_q <= i_priv;
        data_q <= i_data;
      end
      if (capture_old) begin
        old_cra_q <= i_cra;
        old_crb_q <= i_crb;
        err_q     <= err_now;
      end
    end
  end

  assign o_ack     = (state_q == S_IDLE);
  assign o_tid     = tid_q;
  assign o_addr    = addr_q;
  assign o_wra     = wra_q;
  assign o_wrb     = wrb_q;
  assign o_wri     = wri_q;
  assign o_cra     = cra_q;
  assign o_crb     = crb_q;
  assign o_rsp_val = (state_q == S_RSP);
  assign o_rsp_tid = tid_q;
  assign o_rsp_cra = old_cra_q;
  assign o_rsp_crb = old_crb_q;
  assign o_rsp_err = err_q;

endmodule
